// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter for the shared register-file read port: registers the mux
// select at ISSUE, captures mux data at RETURN, with an optional exclusive-lock mode.
module rf_read_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [NUM_REQ-1:0]        lock,
   output logic [ADDR_W-1:0]         rf_sel,
   input  logic [DATA_W-1:0]         rf_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rdata,
   output logic                      busy,
   output logic                      dbg_locked
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic {ST_UNLOCKED, ST_LOCKED} lock_state_e;

   // Handshake: req[i] is held until ack[i] pulses for one cycle with rdata valid;
   // a req still high at the edge after the ack is treated as a fresh request.
   lock_state_e              state_q, state_d;
   logic [IDX_W-1:0]         lock_owner_q, lock_owner_d;
   logic [IDX_W-1:0]         owner_q, owner_d;
   logic [IDX_W-1:0]         last_grant_q, last_grant_d;
   logic                     issue_valid_q, issue_valid_d;
   logic [ADDR_W-1:0]        rf_sel_q, rf_sel_d;
   logic [DATA_W-1:0]        rdata_q, rdata_d;
   logic [NUM_REQ-1:0]       ack_q, ack_d;

   logic [NUM_REQ-1:0]       inflight;
   logic [NUM_REQ-1:0]       eligible;
   logic                     lock_hold;
   logic                     grant;
   logic [IDX_W-1:0]         winner;
   logic [IDX_W-1:0]         cand;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_UNLOCKED;
         lock_owner_q  <= '0;
         owner_q       <= '0;
         last_grant_q  <= IDX_W'(NUM_REQ - 1);
         issue_valid_q <= 1'b0;
         rf_sel_q      <= '0;
         rdata_q       <= '0;
         ack_q         <= '0;
      end else begin
         state_q       <= state_d;
         lock_owner_q  <= lock_owner_d;
         owner_q       <= owner_d;
         last_grant_q  <= last_grant_d;
         issue_valid_q <= issue_valid_d;
         rf_sel_q      <= rf_sel_d;
         rdata_q       <= rdata_d;
         ack_q         <= ack_d;
      end
   end

   always_comb begin
      inflight      = issue_valid_q ? (ONE_HOT0 << owner_q) : '0;
      lock_hold     = (state_q == ST_LOCKED) && lock[lock_owner_q];
      eligible      = req & ~inflight;
      if (lock_hold) eligible = eligible & (ONE_HOT0 << lock_owner_q);

      // While locked, last_grant equals the lock owner, so a release searches from owner+1.
      grant  = 1'b0;
      winner = last_grant_q;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(last_grant_q) + 1 + k) % NUM_REQ);
         if (!grant && eligible[cand]) begin
            grant  = 1'b1;
            winner = cand;
         end
      end

      state_d       = state_q;
      lock_owner_d  = lock_owner_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      rf_sel_d      = rf_sel_q;
      issue_valid_d = grant;

      if (grant) begin
         rf_sel_d = addr[int'(winner)*ADDR_W +: ADDR_W];
         owner_d  = winner;
         if (!lock_hold) last_grant_d = winner;
      end

      if (!lock_hold) begin
         state_d = ST_UNLOCKED;
         if (grant && lock[winner]) begin
            state_d      = ST_LOCKED;
            lock_owner_d = winner;
         end
      end

      ack_d   = issue_valid_q ? (ONE_HOT0 << owner_q) : '0;
      rdata_d = issue_valid_q ? rf_data : rdata_q;
   end

   assign rf_sel     = rf_sel_q;
   assign ack        = ack_q;
   assign rdata      = rdata_q;
   assign busy       = issue_valid_q;
   assign dbg_locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Bench for rf_read_arbiter: a cycle-by-cycle vector table plus a hand-written
// lock-idle sequence, with a register-file model behind rf_sel.
module tb_rf_read_arbiter;

   logic        clk;
   logic        reset_n;
   logic [2:0]  req;
   logic [11:0] addr;
   logic [2:0]  lock;
   logic [3:0]  rf_sel;
   logic [15:0] rf_data;
   logic [2:0]  ack;
   logic [15:0] rdata;
   logic        busy;
   logic        dbg_locked;

   int n_checks = 0;
   int n_fail   = 0;
   logic mon_en = 1'b0;

   logic [15:0] regs [16];

   rf_read_arbiter #(.NUM_REQ(3), .ADDR_W(4), .DATA_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .addr       (addr),
      .lock       (lock),
      .rf_sel     (rf_sel),
      .rf_data    (rf_data),
      .ack        (ack),
      .rdata      (rdata),
      .busy       (busy),
      .dbg_locked (dbg_locked)
   );

   assign rf_data = regs[rf_sel];

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic [2:0]  req;
      logic [11:0] addr;
      logic [2:0]  lock;
      logic [3:0]  e_sel;
      logic [2:0]  e_ack;
      logic [15:0] e_rdata;
      logic        e_busy;
      logic        e_locked;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst_n, input logic [2:0] rq, input logic [11:0] ad,
                      input logic [2:0] lk, input logic [3:0] sel, input logic [2:0] ak,
                      input logic [15:0] rd, input logic bz, input logic lkd);
      vec_t v;
      v.rst_n = rst_n; v.req = rq; v.addr = ad; v.lock = lk;
      v.e_sel = sel; v.e_ack = ak; v.e_rdata = rd; v.e_busy = bz; v.e_locked = lkd;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // driver: apply inputs mid-cycle, then wait one rising edge plus settle
   task automatic step(input logic rst_n, input logic [2:0] rq, input logic [11:0] ad,
                       input logic [2:0] lk);
      @(negedge clk);
      reset_n = rst_n; req = rq; addr = ad; lock = lk;
      @(posedge clk);
      #1;
   endtask

   // ack must never be multi-hot
   always @(negedge clk) begin
      if (mon_en) check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
   end

   initial begin
      bit seen;
      reset_n = 1'b0; req = '0; addr = '0; lock = '0;
      for (int i = 0; i < 16; i++) regs[i] = 16'h5A00 + 16'(i);
      regs[10] = 16'h1234;

      //   rst req     addr     lock    sel   ack     rdata     busy lkd
      add(0, 3'b000, 12'h000, 3'b000, 4'h0, 3'b000, 16'h0000, 0, 0);
      add(0, 3'b000, 12'h000, 3'b000, 4'h0, 3'b000, 16'h0000, 0, 0);
      // single read after reset
      add(1, 3'b001, 12'h00A, 3'b000, 4'hA, 3'b000, 16'h0000, 1, 0);
      add(1, 3'b001, 12'h00A, 3'b000, 4'hA, 3'b001, 16'h1234, 0, 0);
      add(1, 3'b000, 12'h00A, 3'b000, 4'hA, 3'b000, 16'h1234, 0, 0);
      // round-robin with all three requesting
      add(0, 3'b000, 12'h321, 3'b000, 4'h0, 3'b000, 16'h0000, 0, 0);
      add(1, 3'b111, 12'h321, 3'b000, 4'h1, 3'b000, 16'h0000, 1, 0);
      add(1, 3'b111, 12'h321, 3'b000, 4'h2, 3'b001, 16'h5A01, 1, 0);
      add(1, 3'b111, 12'h321, 3'b000, 4'h3, 3'b010, 16'h5A02, 1, 0);
      add(1, 3'b111, 12'h321, 3'b000, 4'h1, 3'b100, 16'h5A03, 1, 0);
      add(1, 3'b111, 12'h321, 3'b000, 4'h2, 3'b001, 16'h5A01, 1, 0);
      add(1, 3'b111, 12'h321, 3'b000, 4'h3, 3'b010, 16'h5A02, 1, 0);
      add(1, 3'b000, 12'h321, 3'b000, 4'h3, 3'b100, 16'h5A03, 0, 0);
      add(1, 3'b000, 12'h321, 3'b000, 4'h3, 3'b000, 16'h5A03, 0, 0);
      // single requester held: one read every two cycles
      add(1, 3'b010, 12'h321, 3'b000, 4'h2, 3'b000, 16'h5A03, 1, 0);
      add(1, 3'b010, 12'h321, 3'b000, 4'h2, 3'b010, 16'h5A02, 0, 0);
      add(1, 3'b010, 12'h321, 3'b000, 4'h2, 3'b000, 16'h5A02, 1, 0);
      add(1, 3'b010, 12'h321, 3'b000, 4'h2, 3'b010, 16'h5A02, 0, 0);
      add(1, 3'b000, 12'h321, 3'b000, 4'h2, 3'b000, 16'h5A02, 0, 0);
      // lock by requester 1 starves requester 0, release grants 0 at the same edge
      add(0, 3'b000, 12'h321, 3'b000, 4'h0, 3'b000, 16'h0000, 0, 0);
      add(1, 3'b011, 12'h321, 3'b010, 4'h1, 3'b000, 16'h0000, 1, 0);
      add(1, 3'b011, 12'h321, 3'b010, 4'h2, 3'b001, 16'h5A01, 1, 1);
      add(1, 3'b011, 12'h321, 3'b010, 4'h2, 3'b010, 16'h5A02, 0, 1);
      add(1, 3'b011, 12'h321, 3'b010, 4'h2, 3'b000, 16'h5A02, 1, 1);
      add(1, 3'b011, 12'h321, 3'b010, 4'h2, 3'b010, 16'h5A02, 0, 1);
      add(1, 3'b011, 12'h321, 3'b000, 4'h1, 3'b000, 16'h5A02, 1, 0);
      add(1, 3'b011, 12'h321, 3'b000, 4'h2, 3'b001, 16'h5A01, 1, 0);
      add(1, 3'b000, 12'h321, 3'b000, 4'h2, 3'b010, 16'h5A02, 0, 0);
      add(1, 3'b000, 12'h321, 3'b000, 4'h2, 3'b000, 16'h5A02, 0, 0);
      // reset while requester 2 is in flight
      add(1, 3'b100, 12'h721, 3'b000, 4'h7, 3'b000, 16'h5A02, 1, 0);
      add(0, 3'b100, 12'h721, 3'b000, 4'h0, 3'b000, 16'h0000, 0, 0);
      add(1, 3'b111, 12'h721, 3'b000, 4'h1, 3'b000, 16'h0000, 1, 0);
      add(1, 3'b000, 12'h721, 3'b000, 4'h1, 3'b001, 16'h5A01, 0, 0);
      add(1, 3'b000, 12'h721, 3'b000, 4'h1, 3'b000, 16'h5A01, 0, 0);
      // idle hold of rf_sel after a grant
      add(1, 3'b001, 12'h725, 3'b000, 4'h5, 3'b000, 16'h5A01, 1, 0);
      add(1, 3'b000, 12'h725, 3'b000, 4'h5, 3'b001, 16'h5A05, 0, 0);
      add(1, 3'b000, 12'h725, 3'b000, 4'h5, 3'b000, 16'h5A05, 0, 0);
      add(1, 3'b000, 12'h725, 3'b000, 4'h5, 3'b000, 16'h5A05, 0, 0);
      // top address value
      add(1, 3'b001, 12'h72F, 3'b000, 4'hF, 3'b000, 16'h5A05, 1, 0);
      add(1, 3'b000, 12'h72F, 3'b000, 4'hF, 3'b001, 16'h5A0F, 0, 0);

      mon_en = 1'b1;
      foreach (vecs[i]) begin
         step(vecs[i].rst_n, vecs[i].req, vecs[i].addr, vecs[i].lock);
         check($sformatf("v%0d rf_sel", i), 32'(rf_sel), 32'(vecs[i].e_sel));
         check($sformatf("v%0d ack", i), 32'(ack), 32'(vecs[i].e_ack));
         check($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
         check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
         check($sformatf("v%0d locked", i), 32'(dbg_locked), 32'(vecs[i].e_locked));
      end

      // locked owner drops req: port idles even though requester 0 is waiting
      step(0, 3'b000, 12'h021, 3'b000);
      step(1, 3'b011, 12'h021, 3'b010);
      step(1, 3'b011, 12'h021, 3'b010);
      check("lock_enter", 32'(dbg_locked), 32'd1);
      for (int c = 0; c < 4; c++) begin
         step(1, 3'b001, 12'h021, 3'b010);
         check($sformatf("idle%0d busy", c), 32'(busy), 32'd0);
         check($sformatf("idle%0d ack0", c), 32'(ack[0]), 32'd0);
      end
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
         step(1, 3'b001, 12'h021, 3'b000);
         if (ack == 3'b001) seen = 1'b1;
      end
      check("release_ack0_seen", 32'(seen), 32'd1);
      check("release_rdata", 32'(rdata), 32'h5A01);
      check("release_unlocked", 32'(dbg_locked), 32'd0);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
